mem_bus_ctrl: RTL and testbench
===============================

Name: mem_bus_ctrl

Overview:
- Downstream of the CPU control unit.
- Converts the control unit's level strobes (mem_rd, mem_wr) plus address/data into a req/ack handshake on the external memory bus.
- Captures read data and returns a one-cycle completion pulse to the control FSM.
- Optional watchdog aborts accesses whose ack never arrives.

Parameters:
ADDR_W, 16, address width in bits
DATA_W, 32, data width in bits (matches instruction/register width)
TIMEOUT_CYCLES, 255, cycles in ACCESS before abort (used only with the watchdog compiled in; must be >= 1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
cpu_rd  in  1  read strobe from control (level)
cpu_wr  in  1  write strobe from control (level)
cpu_addr  in  ADDR_W  access address (from MAR/PC path)
cpu_wdata  in  DATA_W  write data (from MDR path)
cpu_rdata  out  DATA_W  captured read data, held until the next successful read
cpu_done  out  1  one-cycle pulse: access completed
cpu_busy  out  1  high while an access is outstanding
cpu_err  out  1  one-cycle pulse: access aborted by watchdog
mem_req  out  1  bus request, held until ack
mem_we  out  1  1 = write, 0 = read; stable while mem_req is high
mem_addr  out  ADDR_W  bus address; stable while mem_req is high
mem_wdata  out  DATA_W  bus write data; stable while mem_req is high
mem_rdata  in  DATA_W  bus read data, valid when mem_ack is high
mem_ack  in  1  bus acknowledge, sampled only while mem_req is high

Behaviour:
- All outputs are registered.
- Reset (async, immediate): state=IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rdata=0, cpu_done=0, cpu_busy=0, cpu_err=0; watchdog counter=0.
- States: IDLE, ACCESS, DONE, ERR (ERR is reachable only with the watchdog compiled in).
- IDLE:
  - If cpu_wr or cpu_rd is high, latch cpu_addr and cpu_wdata into mem_addr/mem_wdata.
  - Set mem_we=cpu_wr; write wins if both strobes are high.
  - Set mem_req=1 and cpu_busy=1, then go to ACCESS.
  - Otherwise stay in IDLE.
- ACCESS:
  - On mem_ack=1: drop mem_req and cpu_busy. If mem_we=0, set cpu_rdata<=mem_rdata. Go to DONE.
  - Otherwise hold every mem_* output unchanged.
- DONE: cpu_done=1 for exactly this cycle; return to IDLE. No request is accepted in DONE.
- Minimum latency: strobe sampled at edge N; mem_req high at N+1; an ack in that same cycle gives cpu_done high at N+2. Back-to-back access rate is one per 3 cycles.
- Strobes are level-sensitive. Control must deassert them in the cycle cpu_done or cpu_err is high. A strobe still high in the following IDLE cycle starts a new access.
- mem_ack outside ACCESS is ignored.
- Strobe changes during ACCESS/DONE are ignored; address and data stay latched.
- cpu_rdata is unchanged by writes and by aborted accesses.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - Counter clears on entry to ACCESS and increments each ACCESS cycle without ack.
  - When the counter reaches TIMEOUT_CYCLES with no ack, drop mem_req and cpu_busy and go to ERR.
  - ERR: cpu_err=1 for one cycle, then IDLE.
  - An ack arriving in the same cycle the counter expires takes priority and completes normally.
- Undefined: no counter; ACCESS waits indefinitely; cpu_err is tied 0.

Decomposition:
- Shared package cpu_pkg holds:
  - bus_state_e enum (IDLE, ACCESS, DONE, ERR)
  - default ADDR_W/DATA_W localparams shared with the control unit and register files
- No sub-module; the watchdog counter is inline under the macro.

Test Plan:
1. Read, zero-wait: cpu_rd=1, cpu_addr=16'h0010 at edge 0; memory acks mem_rdata=32'hDEADBEEF in the first req cycle -> mem_req=1/mem_we=0/mem_addr=16'h0010 at cycle 1; cpu_done pulse at cycle 2; cpu_rdata=32'hDEADBEEF.
2. Write, 3 wait states: cpu_wr=1, addr 16'h0004, wdata 32'h12345678 -> mem_we=1; mem_addr/mem_wdata stable across 4 req cycles; cpu_done one cycle after ack; cpu_rdata unchanged.
3. Simultaneous cpu_rd=cpu_wr=1 -> write performed (mem_we=1); exactly one access.
4. Reset mid-ACCESS: assert rst between edges -> mem_req and cpu_busy fall immediately; no cpu_done; after release, state is IDLE.
5. With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack -> mem_req drops after 4 cycles; cpu_err pulses once; cpu_rdata unchanged. A late ack afterwards is ignored.
6. Strobe held through cpu_done -> second access starts from the following IDLE cycle (mem_req rises at done+2). Spurious mem_ack in IDLE -> no effect.

Source files
------------

// File: rtl/cpu_pkg.sv
// Types and default widths shared by the CPU control unit, register files and
// the external memory bus controller.
package cpu_pkg;

   localparam int CPU_ADDR_W = 16;
   localparam int CPU_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2,
      ERR    = 2'd3
   } bus_state_e;

endpackage

// File: rtl/mem_bus_ctrl.sv
// Turns the control unit's level read/write strobes into a req/ack memory bus
// transaction. Defining MEM_TIMEOUT_EN compiles in a watchdog that aborts unacked accesses.
module mem_bus_ctrl
   import cpu_pkg::*;
#(
   parameter int ADDR_W         = CPU_ADDR_W,
   parameter int DATA_W         = CPU_DATA_W,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_rd,
   input  logic              cpu_wr,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_done,
   output logic              cpu_busy,
   output logic              cpu_err,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack
);

   // Handshake: mem_req rises with mem_we/mem_addr/mem_wdata already valid and
   // all four stay frozen until the cycle mem_ack is sampled high; mem_ack is
   // ignored whenever no request is outstanding.

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("mem_bus_ctrl: TIMEOUT_CYCLES must be >= 1");
   end

   bus_state_e        state, state_nxt;
   logic              timeout;

   logic              req_nxt, we_nxt, done_nxt, busy_nxt, err_nxt;
   logic [ADDR_W-1:0] addr_nxt;
   logic [DATA_W-1:0] wdata_nxt, rdata_nxt;

   logic              strobe;
   assign strobe = cpu_rd | cpu_wr;

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [CNT_W-1:0] wd_cnt;

   // Cleared whenever we are outside ACCESS, so every access starts from zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wd_cnt <= '0;
      end else if (state != ACCESS) begin
         wd_cnt <= '0;
      end else if (!mem_ack) begin
         wd_cnt <= wd_cnt + 1'b1;
      end
   end

   assign timeout = (state == ACCESS) && !mem_ack &&
                    (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (strobe) state_nxt = ACCESS;
         ACCESS: begin
            if (mem_ack)      state_nxt = DONE;
            else if (timeout) state_nxt = ERR;
         end
         DONE:    state_nxt = IDLE;
         ERR:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Next values for the registered outputs; anything not touched holds.
   always_comb begin
      req_nxt   = mem_req;
      we_nxt    = mem_we;
      addr_nxt  = mem_addr;
      wdata_nxt = mem_wdata;
      rdata_nxt = cpu_rdata;
      busy_nxt  = cpu_busy;
      done_nxt  = 1'b0;
      err_nxt   = 1'b0;
      case (state)
         IDLE: begin
            if (strobe) begin
               addr_nxt  = cpu_addr;
               wdata_nxt = cpu_wdata;
               we_nxt    = cpu_wr;
               req_nxt   = 1'b1;
               busy_nxt  = 1'b1;
            end
         end
         ACCESS: begin
            if (mem_ack) begin
               req_nxt  = 1'b0;
               busy_nxt = 1'b0;
               done_nxt = 1'b1;
               if (!mem_we) rdata_nxt = mem_rdata;
            end else if (timeout) begin
               req_nxt  = 1'b0;
               busy_nxt = 1'b0;
               err_nxt  = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         cpu_rdata <= '0;
         cpu_done  <= 1'b0;
         cpu_busy  <= 1'b0;
         cpu_err   <= 1'b0;
      end else begin
         mem_req   <= req_nxt;
         mem_we    <= we_nxt;
         mem_addr  <= addr_nxt;
         mem_wdata <= wdata_nxt;
         cpu_rdata <= rdata_nxt;
         cpu_done  <= done_nxt;
         cpu_busy  <= busy_nxt;
         cpu_err   <= err_nxt;
      end
   end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl: vector table, hand-written corner
// sequences and randomized accesses against a memory-level reference model.
module tb_mem_bus_ctrl;

   localparam int AW = 16;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cpu_rd = 1'b0, cpu_wr = 1'b0;
   logic [AW-1:0] cpu_addr = '0;
   logic [DW-1:0] cpu_wdata = '0;
   logic [DW-1:0] cpu_rdata;
   logic          cpu_done, cpu_busy, cpu_err;
   logic          mem_req, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata = '0;
   logic          mem_ack = 1'b0;

   mem_bus_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst(rst),
      .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_busy(cpu_busy), .cpu_err(cpu_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] last_rdata = '0;
   logic [DW-1:0] bus_mem   [logic [AW-1:0]];
   logic [DW-1:0] model_mem [logic [AW-1:0]];

   typedef struct {
      logic          wr;
      logic          rd;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      int            waits;
      logic [DW-1:0] bus_rdata;
      logic          exp_we;
      logic [DW-1:0] exp_rdata;
   } vec_t;

   vec_t vecs[5];

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] fill_value(input logic [AW-1:0] a);
      return {16'hA5A5, a};
   endfunction

   function automatic logic [DW-1:0] bus_read(input logic [AW-1:0] a);
      return bus_mem.exists(a) ? bus_mem[a] : fill_value(a);
   endfunction

   function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
      return model_mem.exists(a) ? model_mem[a] : fill_value(a);
   endfunction

   // One complete access; the expected cpu_rdata after completion is taken
   // from the front of exp_q.
   task automatic run_access(input logic wr, input logic rd, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wdata, input int waits,
                             input logic [DW-1:0] bus_rdata, input logic exp_we,
                             input bit use_mem);
      logic [DW-1:0] exp_rd;
      @(negedge clk);
      cpu_wr = wr; cpu_rd = rd; cpu_addr = addr; cpu_wdata = wdata;
      @(posedge clk); #1;
      cpu_wr = 1'b0; cpu_rd = 1'b0;
      cpu_addr = AW'($urandom); cpu_wdata = $urandom;
      check("req_rise", mem_req, 1'b1);
      check("busy_rise", cpu_busy, 1'b1);
      check("we", mem_we, exp_we);
      check("addr", mem_addr, addr);
      check("wdata", mem_wdata, wdata);
      for (int i = 0; i < waits; i++) begin
         mem_ack = 1'b0;
         @(posedge clk); #1;
         check("req_hold", mem_req, 1'b1);
         check("addr_hold", mem_addr, addr);
         check("wdata_hold", mem_wdata, wdata);
         check("no_early_done", cpu_done, 1'b0);
      end
      mem_ack = 1'b1;
      if (use_mem) begin
         if (mem_we) bus_mem[mem_addr] = mem_wdata;
         mem_rdata = bus_read(mem_addr);
      end else begin
         mem_rdata = bus_rdata;
      end
      @(posedge clk); #1;
      mem_ack = 1'b0;
      mem_rdata = $urandom;
      exp_rd = exp_q.pop_front();
      check("done_pulse", cpu_done, 1'b1);
      check("req_drop", mem_req, 1'b0);
      check("busy_drop", cpu_busy, 1'b0);
      check("no_err", cpu_err, 1'b0);
      check("rdata", cpu_rdata, exp_rd);
      last_rdata = exp_rd;
      @(posedge clk); #1;
      check("done_one_cycle", cpu_done, 1'b0);
      check("idle_no_req", mem_req, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL sim_timeout: simulation exceeded its time limit");
      $fatal(1, "time limit");
   end

   initial begin
      vecs[0] = '{1'b0, 1'b1, 16'h0010, 32'h0, 0, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF};
      vecs[1] = '{1'b1, 1'b0, 16'h0004, 32'h12345678, 3, 32'h0BADF00D, 1'b1, 32'hDEADBEEF};
      vecs[2] = '{1'b1, 1'b1, 16'h0008, 32'hCAFEF00D, 1, 32'h11111111, 1'b1, 32'hDEADBEEF};
      vecs[3] = '{1'b0, 1'b1, 16'hFFFF, 32'h0, 2, 32'h80000001, 1'b0, 32'h80000001};
      vecs[4] = '{1'b0, 1'b1, 16'h0000, 32'hFFFFFFFF, 0, 32'h00000000, 1'b0, 32'h00000000};

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      check("rst_req", mem_req, 1'b0);
      check("rst_we", mem_we, 1'b0);
      check("rst_addr", mem_addr, '0);
      check("rst_wdata", mem_wdata, '0);
      check("rst_rdata", cpu_rdata, '0);
      check("rst_done", cpu_done, 1'b0);
      check("rst_busy", cpu_busy, 1'b0);
      check("rst_err", cpu_err, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      foreach (vecs[i]) begin
         exp_q.push_back(vecs[i].exp_rdata);
         run_access(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata, vecs[i].waits,
                    vecs[i].bus_rdata, vecs[i].exp_we, 1'b0);
      end
      check("single_access", mem_req, 1'b0);

      // Reset in the middle of an access
      exp_q.push_back(32'h5A5A0001);
      run_access(1'b0, 1'b1, 16'h0100, 32'h0, 0, 32'h5A5A0001, 1'b0, 1'b0);
      @(negedge clk);
      cpu_rd = 1'b1; cpu_addr = 16'h0020;
      @(posedge clk); #1;
      cpu_rd = 1'b0;
      check("mid_req", mem_req, 1'b1);
      #2 rst = 1'b1;
      #1;
      check("async_req", mem_req, 1'b0);
      check("async_busy", cpu_busy, 1'b0);
      check("async_rdata", cpu_rdata, '0);
      last_rdata = '0;
      @(negedge clk);
      rst = 1'b0;
      mem_ack = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         check("post_rst_done", cpu_done, 1'b0);
         check("post_rst_req", mem_req, 1'b0);
      end
      mem_ack = 1'b0;
      exp_q.push_back(32'h0000BEEF);
      run_access(1'b0, 1'b1, 16'h0022, 32'h0, 0, 32'h0000BEEF, 1'b0, 1'b0);

      // Strobe held through cpu_done starts a second access at done+2
      @(negedge clk);
      cpu_rd = 1'b1; cpu_addr = 16'h0030;
      @(posedge clk); #1;
      check("held_req1", mem_req, 1'b1);
      mem_ack = 1'b1; mem_rdata = 32'h01020304;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      check("held_done1", cpu_done, 1'b1);
      check("held_rdata1", cpu_rdata, 32'h01020304);
      @(posedge clk); #1;
      check("held_idle_req", mem_req, 1'b0);
      check("held_idle_done", cpu_done, 1'b0);
      @(posedge clk); #1;
      cpu_rd = 1'b0;
      check("held_req2", mem_req, 1'b1);
      check("held_we2", mem_we, 1'b0);
      check("held_addr2", mem_addr, 16'h0030);
      mem_ack = 1'b1; mem_rdata = 32'h05060708;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      check("held_done2", cpu_done, 1'b1);
      check("held_rdata2", cpu_rdata, 32'h05060708);
      last_rdata = 32'h05060708;
      @(posedge clk); #1;

      // Spurious ack while idle
      mem_ack = 1'b1; mem_rdata = 32'hBAADBAAD;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("spur_req", mem_req, 1'b0);
         check("spur_busy", cpu_busy, 1'b0);
         check("spur_done", cpu_done, 1'b0);
         check("spur_rdata", cpu_rdata, last_rdata);
      end
      mem_ack = 1'b0;

`ifdef MEM_TIMEOUT_EN
      begin
         int req_cycles = 0;
         @(negedge clk);
         cpu_rd = 1'b1; cpu_addr = 16'h0040;
         @(posedge clk); #1;
         cpu_rd = 1'b0;
         while (mem_req && req_cycles < 20) begin
            req_cycles++;
            @(posedge clk); #1;
         end
         check("to_req_cycles", req_cycles, 4);
         check("to_err", cpu_err, 1'b1);
         check("to_busy", cpu_busy, 1'b0);
         check("to_done", cpu_done, 1'b0);
         check("to_rdata", cpu_rdata, last_rdata);
         mem_ack = 1'b1; mem_rdata = 32'h77777777;
         @(posedge clk); #1;
         check("to_err_once", cpu_err, 1'b0);
         @(posedge clk); #1;
         mem_ack = 1'b0;
         check("late_ack_done", cpu_done, 1'b0);
         check("late_ack_req", mem_req, 1'b0);
         check("late_ack_rdata", cpu_rdata, last_rdata);
      end
`else
      @(negedge clk);
      cpu_rd = 1'b1; cpu_addr = 16'h0040;
      @(posedge clk); #1;
      cpu_rd = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      check("wait_req", mem_req, 1'b1);
      check("wait_err", cpu_err, 1'b0);
      mem_ack = 1'b1; mem_rdata = 32'h66666666;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      check("wait_done", cpu_done, 1'b1);
      check("wait_rdata", cpu_rdata, 32'h66666666);
      last_rdata = 32'h66666666;
      @(posedge clk); #1;
`endif

      // Random accesses against a memory-level model
      for (int n = 0; n < 40; n++) begin
         logic          wr, rd;
         logic [AW-1:0] addr;
         logic [DW-1:0] wdata;
         int            sel;
         sel   = $urandom_range(0, 2);
         wr    = (sel != 1);
         rd    = (sel != 0);
         addr  = AW'($urandom_range(0, 7) * 4);
         wdata = $urandom;
         if (wr) begin
            model_mem[addr] = wdata;
            exp_q.push_back(last_rdata);
         end else begin
            exp_q.push_back(model_read(addr));
         end
         run_access(wr, rd, addr, wdata, $urandom_range(0, 3), '0, wr, 1'b1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
